// File: rtl/pool_channel_scheduler.sv
// Round-robin arbiter sharing one maxpool engine among NUM_CH conv channels.
// Sequences the engine en/done handshake, with a per-run watchdog and completion counter.
//
// state   | meaning
// IDLE    | no grant; picks next eligible channel from ptr when done_pool is low
// RUN     | pool_en high, waiting for done_pool or watchdog expiry
// RELEASE | pool_en low, grant held until the engine drops done_pool
module pool_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CW             = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              done_pool,
  input  logic              err_clr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     sel,
  output logic              pool_en,
  output logic [NUM_CH-1:0] ack,
  output logic              busy,
  output logic              timeout_err,
  output logic [CW-1:0]     err_ch,
  output logic [15:0]       pool_count
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t            state;
  logic [CW-1:0]     ptr;
  logic [WW-1:0]     wd_cnt;
  logic [NUM_CH-1:0] eligible;
  logic              pick_valid;
  logic [CW-1:0]     pick_idx;
  int                cand;

  // Scan downward so the last hit written is the closest one at or after ptr.
  always_comb begin
    eligible   = req & ch_enable;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NUM_CH;
      if (eligible[CW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = CW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      sel         <= '0;
      pool_en     <= 1'b0;
      ack         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_ch      <= '0;
      pool_count  <= '0;
      ptr         <= '0;
      wd_cnt      <= '0;
    end else begin
      ack <= '0;
      // A timeout set later in this block overrides a simultaneous clear.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid && !done_pool) begin
            state   <= RUN;
            grant   <= NUM_CH'(1) << pick_idx;
            sel     <= pick_idx;
            pool_en <= 1'b1;
            busy    <= 1'b1;
            wd_cnt  <= '0;
          end
        end
        RUN: begin
          if (done_pool) begin
            state   <= RELEASE;
            pool_en <= 1'b0;
            ack     <= grant;
            if (pool_count != 16'hFFFF) pool_count <= pool_count + 16'd1;
          end else if (wd_cnt == WD_LAST) begin
            state       <= RELEASE;
            pool_en     <= 1'b0;
            timeout_err <= 1'b1;
            err_ch      <= sel;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        RELEASE: begin
          if (!done_pool) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= (sel == LAST_CH) ? '0 : sel + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= '0;
          pool_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_channel_scheduler.sv
// Scoreboard bench for pool_channel_scheduler: engine model plus grant/ack/pool_en logs
// compared against expected sequences queued by each scenario task.
module tb_pool_channel_scheduler;
  localparam int NCH = 4;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] base_req = '0;
  logic [NCH-1:0] req;
  logic [NCH-1:0] ch_enable = 4'hF;
  logic           done_pool;
  logic           err_clr = 1'b0;
  logic [NCH-1:0] grant;
  logic [1:0]     sel;
  logic           pool_en;
  logic [NCH-1:0] ack;
  logic           busy;
  logic           timeout_err;
  logic [1:0]     err_ch;
  logic [15:0]    pool_count;

  logic eng_auto = 1'b1;
  logic force_done = 1'b0;
  logic auto_clr = 1'b0;
  logic model_done = 1'b0;
  int   eng_delay = 5;
  int   model_cnt = 0;
  logic pool_en_d = 1'b0;
  int   pen_len = 0;

  logic [NCH-1:0] grant_log[$];
  logic [NCH-1:0] ack_log[$];
  int             pen_log[$];
  logic [NCH-1:0] exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  assign done_pool = eng_auto ? model_done : force_done;
  assign req = base_req & ~(auto_clr ? ack : 4'b0000);

  pool_channel_scheduler #(.NUM_CH(NCH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .ch_enable(ch_enable),
    .done_pool(done_pool), .err_clr(err_clr), .grant(grant), .sel(sel),
    .pool_en(pool_en), .ack(ack), .busy(busy), .timeout_err(timeout_err),
    .err_ch(err_ch), .pool_count(pool_count)
  );

  always #5 clk = ~clk;

  // Engine model and event logger, sampled 2ns after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (!pool_en) begin
      model_cnt  = 0;
      model_done = 1'b0;
    end else begin
      model_cnt++;
      if (model_cnt >= eng_delay) model_done = 1'b1;
    end
    if (pool_en && !pool_en_d) grant_log.push_back(grant);
    if (pool_en) pen_len++;
    if (!pool_en && pool_en_d) begin
      pen_log.push_back(pen_len);
      pen_len = 0;
    end
    if (ack != '0) ack_log.push_back(ack);
    pool_en_d = pool_en;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic clear_logs();
    grant_log.delete();
    ack_log.delete();
    pen_log.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; base_req = '0; err_clr = 1'b0; force_done = 1'b0;
    eng_auto = 1'b1; auto_clr = 1'b0; ch_enable = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({grant, sel, pool_en, ack, busy, timeout_err, err_ch, pool_count} !== 31'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {grant, sel, pool_en, ack, busy, timeout_err, err_ch, pool_count});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    logic [NCH-1:0] exp;
    do_reset();
    base_req = 4'b0100;
    exp_q.push_back(4'b0100);
    @(negedge clk);
    n_chk++;
    if (grant !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", grant); else n_pass++;
    n_chk++;
    if (sel !== 2'd2) $display("FAIL single_sel: got %0d expected 2", sel); else n_pass++;
    n_chk++;
    if ({pool_en, busy} !== 2'b11) $display("FAIL single_en_busy: got %b expected 11", {pool_en, busy}); else n_pass++;
    for (int i = 0; i < 30 && ack == '0; i++) @(negedge clk);
    exp = exp_q.pop_front();
    n_chk++;
    if (ack !== exp) $display("FAIL single_ack: got %b expected %b", ack, exp); else n_pass++;
    base_req = '0;
    @(negedge clk);
    n_chk++;
    if (ack !== 4'b0000) $display("FAIL single_ack_width: got %b expected 0000", ack); else n_pass++;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done_pool !== 1'b0)
      $display("FAIL single_busy_low: got busy=%b done=%b expected 0 0", busy, done_pool);
    else n_pass++;
    n_chk++;
    if (pool_count !== 16'd1) $display("FAIL single_count: got %0d expected 1", pool_count); else n_pass++;
    n_chk++;
    if (pen_log.size() != 1 || pen_log[0] != 5)
      $display("FAIL single_en_len: got %0d runs first %0d expected 1 run of 5", pen_log.size(), pen_log[0]);
    else n_pass++;
  endtask

  task automatic test_rr_fair();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [NCH-1:0] exp;
    do_reset();
    auto_clr = 1'b1;
    base_req = 4'hF;
    foreach (order[k]) exp_q.push_back(4'b0001 << order[k]);
    for (int i = 0; i < 300 && grant_log.size() < 5; i++) @(negedge clk);
    base_req = '0;
    for (int i = 0; i < 30 && busy !== 1'b0; i++) @(negedge clk);
    n_chk++;
    if (grant_log.size() != 5 || ack_log.size() != 5)
      $display("FAIL rr_counts: got %0d grants %0d acks expected 5 5", grant_log.size(), ack_log.size());
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      exp = exp_q.pop_front();
      n_chk++;
      if (grant_log[k] !== exp || ack_log[k] !== exp)
        $display("FAIL rr_order[%0d]: got grant %b ack %b expected %b", k, grant_log[k], ack_log[k], exp);
      else n_pass++;
    end
    n_chk++;
    if (pool_count !== 16'd5) $display("FAIL rr_count: got %0d expected 5", pool_count); else n_pass++;
  endtask

  task automatic test_masking();
    int order[4] = '{1, 3, 1, 3};
    logic [NCH-1:0] exp;
    do_reset();
    auto_clr = 1'b1;
    ch_enable = 4'b1010;
    base_req = 4'hF;
    foreach (order[k]) exp_q.push_back(4'b0001 << order[k]);
    for (int i = 0; i < 300 && grant_log.size() < 4; i++) @(negedge clk);
    base_req = '0;
    for (int i = 0; i < 30 && busy !== 1'b0; i++) @(negedge clk);
    n_chk++;
    if (grant_log.size() != 4 || ack_log.size() != 4)
      $display("FAIL mask_counts: got %0d grants %0d acks expected 4 4", grant_log.size(), ack_log.size());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      n_chk++;
      if (grant_log[k] !== exp || ack_log[k] !== exp)
        $display("FAIL mask_order[%0d]: got grant %b ack %b expected %b", k, grant_log[k], ack_log[k], exp);
      else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    eng_auto = 1'b0;
    force_done = 1'b0;
    base_req = 4'b0010;
    for (int i = 0; i < 40 && timeout_err !== 1'b1; i++) @(negedge clk);
    n_chk++;
    if (timeout_err !== 1'b1 || err_ch !== 2'd1)
      $display("FAIL wd_flag: got err=%b ch=%0d expected 1 1", timeout_err, err_ch);
    else n_pass++;
    n_chk++;
    if (pen_log.size() != 1 || pen_log[0] != TO)
      $display("FAIL wd_en_len: got %0d runs first %0d expected 1 run of %0d", pen_log.size(), pen_log[0], TO);
    else n_pass++;
    n_chk++;
    if (ack_log.size() != 0 || pool_count !== 16'd0)
      $display("FAIL wd_no_ack: got %0d acks count %0d expected 0 0", ack_log.size(), pool_count);
    else n_pass++;
    eng_auto = 1'b1;
    base_req = 4'hF;
    auto_clr = 1'b1;
    for (int i = 0; i < 40 && grant_log.size() < 2; i++) @(negedge clk);
    base_req = '0;
    n_chk++;
    if (grant_log.size() != 2 || grant_log[1] !== 4'b0100)
      $display("FAIL wd_next_grant: got %0d grants second %b expected 0100", grant_log.size(), grant_log[1]);
    else n_pass++;
    for (int i = 0; i < 30 && busy !== 1'b0; i++) @(negedge clk);
    n_chk++;
    if (timeout_err !== 1'b1) $display("FAIL wd_sticky: got %b expected 1", timeout_err); else n_pass++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++;
    if (timeout_err !== 1'b0) $display("FAIL wd_clear: got %b expected 0", timeout_err); else n_pass++;
  endtask

  task automatic test_stale_and_reset();
    do_reset();
    eng_auto = 1'b0;
    force_done = 1'b1;
    base_req = 4'b0001;
    repeat (5) @(negedge clk);
    n_chk++;
    if (grant !== 4'b0000 || busy !== 1'b0 || grant_log.size() != 0)
      $display("FAIL stale_no_grant: got grant %b busy %b expected 0000 0", grant, busy);
    else n_pass++;
    force_done = 1'b0;
    @(negedge clk);
    n_chk++;
    if (grant !== 4'b0001 || pool_en !== 1'b1)
      $display("FAIL stale_then_grant: got grant %b en %b expected 0001 1", grant, pool_en);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({grant, sel, pool_en, ack, busy, timeout_err, err_ch, pool_count} !== 31'd0)
      $display("FAIL midrun_reset: got %h expected 0",
               {grant, sel, pool_en, ack, busy, timeout_err, err_ch, pool_count});
    else n_pass++;
    n_chk++;
    if (ack_log.size() != 0) $display("FAIL midrun_no_ack: got %0d acks expected 0", ack_log.size()); else n_pass++;
    @(negedge clk);
    base_req = '0;
    eng_auto = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    base_req = 4'b1011;
    for (int i = 0; i < 20 && grant_log.size() < 1; i++) @(negedge clk);
    base_req = '0;
    n_chk++;
    if (grant_log.size() < 1 || grant_log[0] !== 4'b0001)
      $display("FAIL post_reset_grant: got %0d grants first %b expected 0001", grant_log.size(), grant_log[0]);
    else n_pass++;
    for (int i = 0; i < 30 && busy !== 1'b0; i++) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fair();
    test_masking();
    test_watchdog();
    test_stale_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
